// File: rtl/ringbuf_mc.sv
`default_nettype none
// ringbuf_mc: multi-channel audio frame ring buffer. An asynchronous write strobe
// commits one frame; frames are read back by offset from the oldest unread one.
module ringbuf_mc #(
   parameter int WIDTH      = 24,
   parameter int NCH        = 2,
   parameter int DEPTH_LOG2 = 4,
   parameter bit OVERWRITE  = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NCH*WIDTH-1:0]  data_i,
   input  logic                  wpulse_i,
   input  logic                  pop_i,
   input  logic [DEPTH_LOG2-1:0] offset_i,
   output logic [NCH*WIDTH-1:0]  data_o,
   output logic                  valid_o,
   output logic [DEPTH_LOG2:0]   count_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic                  ovf_o,
   output logic                  udf_o,
   input  logic                  clr_i
);
   localparam int FW    = NCH * WIDTH;
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int CW    = DEPTH_LOG2 + 1;
   localparam logic [DEPTH_LOG2:0] CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

   logic [2:0]            sync_q, sync_d;
   logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
   logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic [FW-1:0]         data_q, data_d;
   logic                  valid_q, valid_d;
   logic                  ovf_q, ovf_d;
   logic                  udf_q, udf_d;
   logic [FW-1:0]         mem_q [DEPTH];

   logic                  wr_ev;
   logic                  is_full;
   logic                  is_empty;
   logic                  do_pop;
   logic                  mem_we;
   logic                  ovf_set;
   logic                  udf_set;
   logic [DEPTH_LOG2-1:0] rd_idx;

   always_comb begin
      // sync_q[0]/[1] form the synchroniser, sync_q[2] remembers the previous level
      sync_d   = {sync_q[1:0], wpulse_i};
      wr_ev    = sync_q[1] & ~sync_q[2];
      is_full  = (count_q == CNT_FULL);
      is_empty = (count_q == '0);
      do_pop   = pop_i & ~is_empty;

      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      mem_we  = 1'b0;
      ovf_set = 1'b0;
      udf_set = pop_i & is_empty;

      if (wr_ev) begin
         if (do_pop) begin
            mem_we = 1'b1;
            wptr_d = wptr_q + DEPTH_LOG2'(1);
            rptr_d = rptr_q + DEPTH_LOG2'(1);
         end else if (is_full) begin
            ovf_set = 1'b1;
            if (OVERWRITE) begin
               mem_we = 1'b1;
               wptr_d = wptr_q + DEPTH_LOG2'(1);
               rptr_d = rptr_q + DEPTH_LOG2'(1);
            end
         end else begin
            mem_we  = 1'b1;
            wptr_d  = wptr_q + DEPTH_LOG2'(1);
            count_d = count_q + CW'(1);
         end
      end else if (do_pop) begin
         rptr_d  = rptr_q + DEPTH_LOG2'(1);
         count_d = count_q - CW'(1);
      end

      // Read side sees pre-edge pointers and memory; data updates even when invalid
      rd_idx  = rptr_q + offset_i;
      data_d  = mem_q[rd_idx];
      valid_d = ({1'b0, offset_i} < count_q);

      ovf_d = ovf_set | (ovf_q & ~clr_i);
      udf_d = udf_set | (udf_q & ~clr_i);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[wptr_q] <= data_i;
      end
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;
   assign count_o = count_q;
   assign full_o  = is_full;
   assign empty_o = is_empty;
   assign ovf_o   = ovf_q;
   assign udf_o   = udf_q;

endmodule
`default_nettype wire

// File: tb/tb_ringbuf_mc.sv
`default_nettype none
// tb_ringbuf_mc: directed and randomized checks of ringbuf_mc (OVERWRITE=1 and 0)
// against a queue-based reference model.
module tb_ringbuf_mc;
   localparam int WIDTH = 24;
   localparam int NCH   = 2;
   localparam int DL2   = 4;
   localparam int FW    = WIDTH * NCH;
   localparam int DEPTH = 16;
   typedef logic [FW-1:0] frame_t;

   logic           clk      = 1'b0;
   logic           rst_n    = 1'b1;
   frame_t         data_i   = '0;
   logic           wpulse_i = 1'b0;
   logic           pop_i    = 1'b0;
   logic           clr_i    = 1'b0;
   logic [DL2-1:0] offset_i = '0;

   frame_t         d_o  [2];
   logic           v_o  [2];
   logic [DL2:0]   c_o  [2];
   logic           f_o  [2];
   logic           e_o  [2];
   logic           ov_o [2];
   logic           ud_o [2];

   ringbuf_mc #(.WIDTH(WIDTH), .NCH(NCH), .DEPTH_LOG2(DL2), .OVERWRITE(1'b1)) u_ow (
      .clk(clk), .rst_n(rst_n), .data_i(data_i), .wpulse_i(wpulse_i), .pop_i(pop_i),
      .offset_i(offset_i), .data_o(d_o[0]), .valid_o(v_o[0]), .count_o(c_o[0]),
      .full_o(f_o[0]), .empty_o(e_o[0]), .ovf_o(ov_o[0]), .udf_o(ud_o[0]), .clr_i(clr_i)
   );

   ringbuf_mc #(.WIDTH(WIDTH), .NCH(NCH), .DEPTH_LOG2(DL2), .OVERWRITE(1'b0)) u_dr (
      .clk(clk), .rst_n(rst_n), .data_i(data_i), .wpulse_i(wpulse_i), .pop_i(pop_i),
      .offset_i(offset_i), .data_o(d_o[1]), .valid_o(v_o[1]), .count_o(c_o[1]),
      .full_o(f_o[1]), .empty_o(e_o[1]), .ovf_o(ov_o[1]), .udf_o(ud_o[1]), .clr_i(clr_i)
   );

   always #20 clk = ~clk;

   // Reference model: index 0 overwrites when full, index 1 drops
   frame_t q0[$];
   frame_t q1[$];
   int     pend;
   bit     wp_prev;
   frame_t exp_data  [2];
   bit     exp_valid [2];
   int     exp_cnt   [2];
   bit     exp_ovf   [2];
   bit     exp_udf   [2];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
   endtask

   function automatic frame_t fr(input int k);
      return {24'(k + 'h100), 24'(k)};
   endfunction

   // A strobe first seen high at one edge commits two edges later
   task automatic model_update();
      bit commit;
      commit = (pend == 1);
      if (pend > 0) pend--;
      if (wpulse_i && !wp_prev) pend = 2;
      wp_prev = wpulse_i;
      for (int i = 0; i < 2; i++) begin
         frame_t q[$];
         bit ovs;
         bit uds;
         if (i == 0) q = q0; else q = q1;
         exp_valid[i] = (int'(offset_i) < q.size());
         exp_data[i]  = exp_valid[i] ? q[offset_i] : '0;
         ovs = 1'b0;
         uds = (pop_i && q.size() == 0);
         if (commit) begin
            if (pop_i && q.size() > 0) begin
               void'(q.pop_front());
               q.push_back(data_i);
            end else if (q.size() == DEPTH) begin
               ovs = 1'b1;
               if (i == 0) begin
                  void'(q.pop_front());
                  q.push_back(data_i);
               end
            end else begin
               q.push_back(data_i);
            end
         end else if (pop_i && q.size() > 0) begin
            void'(q.pop_front());
         end
         exp_ovf[i] = ovs | (exp_ovf[i] & ~clr_i);
         exp_udf[i] = uds | (exp_udf[i] & ~clr_i);
         exp_cnt[i] = q.size();
         if (i == 0) q0 = q; else q1 = q;
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("d%0d_count", i), 64'(c_o[i]), 64'(exp_cnt[i]));
         chk($sformatf("d%0d_full", i), 64'(f_o[i]), 64'(exp_cnt[i] == DEPTH));
         chk($sformatf("d%0d_empty", i), 64'(e_o[i]), 64'(exp_cnt[i] == 0));
         chk($sformatf("d%0d_valid", i), 64'(v_o[i]), 64'(exp_valid[i]));
         chk($sformatf("d%0d_ovf", i), 64'(ov_o[i]), 64'(exp_ovf[i]));
         chk($sformatf("d%0d_udf", i), 64'(ud_o[i]), 64'(exp_udf[i]));
         if (exp_valid[i]) chk($sformatf("d%0d_data", i), 64'(d_o[i]), 64'(exp_data[i]));
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_update();
      @(negedge clk);
      check_all();
   endtask

   // Called at a negedge; asserts reset asynchronously mid-cycle
   task automatic do_reset();
      wpulse_i = 1'b0;
      pop_i    = 1'b0;
      clr_i    = 1'b0;
      #5 rst_n = 1'b0;
      #1;
      q0.delete();
      q1.delete();
      pend    = 0;
      wp_prev = 1'b0;
      for (int i = 0; i < 2; i++) begin
         exp_cnt[i]   = 0;
         exp_valid[i] = 1'b0;
         exp_data[i]  = '0;
         exp_ovf[i]   = 1'b0;
         exp_udf[i]   = 1'b0;
      end
      check_all();
      chk("d0_rst_data", 64'(d_o[0]), 64'd0);
      chk("d1_rst_data", 64'(d_o[1]), 64'd0);
      @(negedge clk);
      #5 rst_n = 1'b1;
      cycle();
   endtask

   task automatic write_frame(input frame_t f, input int hi);
      data_i = f;
      cycle();
      #5 wpulse_i = 1'b1;
      repeat (hi) cycle();
      wpulse_i = 1'b0;
      repeat (3) cycle();
   endtask

   task automatic read_at(input int off);
      offset_i = DL2'(off);
      cycle();
   endtask

   initial begin
      int base;
      int hi_left;
      int lo_left;

      @(negedge clk);
      do_reset();

      // Fill with 16 frames, then random-access reads
      for (int k = 0; k < 16; k++) write_frame(fr(k), 2);
      chk("t1_count", 64'(c_o[0]), 64'd16);
      chk("t1_full", 64'(f_o[0]), 64'd1);
      read_at(0);
      chk("t1_off0", 64'(d_o[0][23:0]), 64'd0);
      read_at(3);
      chk("t1_off3", 64'(d_o[0][23:0]), 64'd3);
      chk("t1_off3_ch1", 64'(d_o[0][47:24]), 64'h103);
      read_at(15);
      chk("t1_off15", 64'(d_o[0][23:0]), 64'd15);
      chk("t1_off15_valid", 64'(v_o[0]), 64'd1);

      // One pop
      pop_i = 1'b1;
      cycle();
      pop_i = 1'b0;
      chk("t2_count", 64'(c_o[0]), 64'd15);
      read_at(0);
      chk("t2_off0", 64'(d_o[0][23:0]), 64'd1);
      read_at(15);
      chk("t2_off15_valid", 64'(v_o[0]), 64'd0);

      // Write while full: overwrite vs drop
      @(negedge clk);
      do_reset();
      for (int k = 0; k < 16; k++) write_frame(fr(k), 2);
      write_frame(fr(16), 2);
      chk("t3_ow_count", 64'(c_o[0]), 64'd16);
      chk("t3_ow_ovf", 64'(ov_o[0]), 64'd1);
      chk("t3_dr_ovf", 64'(ov_o[1]), 64'd1);
      read_at(0);
      chk("t3_ow_off0", 64'(d_o[0][23:0]), 64'd1);
      chk("t3_dr_off0", 64'(d_o[1][23:0]), 64'd0);
      read_at(15);
      chk("t3_ow_off15", 64'(d_o[0][23:0]), 64'd16);
      chk("t3_dr_off15", 64'(d_o[1][23:0]), 64'd15);
      clr_i = 1'b1;
      cycle();
      clr_i = 1'b0;
      chk("t3_ovf_clr", 64'(ov_o[0]), 64'd0);

      // 130 ns strobe: exactly one write, landing on the third sampling edge
      @(negedge clk);
      do_reset();
      write_frame(fr(40), 2);
      base = int'(c_o[0]);
      data_i = fr(41);
      cycle();
      #5 wpulse_i = 1'b1;
      fork
         #130 wpulse_i = 1'b0;
      join_none
      cycle();
      chk("t4_edge1", 64'(c_o[0]), 64'(base));
      cycle();
      chk("t4_edge2", 64'(c_o[0]), 64'(base));
      cycle();
      chk("t4_edge3", 64'(c_o[0]), 64'(base + 1));
      repeat (4) cycle();
      chk("t4_once", 64'(c_o[0]), 64'(base + 1));

      // Underflow, clear, and write+pop at count 5
      @(negedge clk);
      do_reset();
      pop_i = 1'b1;
      cycle();
      pop_i = 1'b0;
      chk("t5_udf", 64'(ud_o[0]), 64'd1);
      chk("t5_udf_count", 64'(c_o[0]), 64'd0);
      clr_i = 1'b1;
      cycle();
      clr_i = 1'b0;
      chk("t5_udf_clr", 64'(ud_o[0]), 64'd0);
      for (int k = 0; k < 5; k++) write_frame(fr(50 + k), 2);
      chk("t5_pre", 64'(c_o[0]), 64'd5);
      data_i = fr(60);
      cycle();
      #5 wpulse_i = 1'b1;
      cycle();
      cycle();
      pop_i = 1'b1;
      cycle();
      pop_i = 1'b0;
      wpulse_i = 1'b0;
      repeat (2) cycle();
      chk("t5_wr_pop", 64'(c_o[0]), 64'd5);
      read_at(4);
      chk("t5_newest", 64'(d_o[0][23:0]), 64'd60);

      // Reset mid-fill, then a fresh write
      @(negedge clk);
      do_reset();
      for (int k = 0; k < 7; k++) write_frame(fr(70 + k), 3);
      chk("t6_pre", 64'(c_o[0]), 64'd7);
      do_reset();
      write_frame(fr(99), 2);
      read_at(0);
      chk("t6_new", 64'(d_o[0]), 64'(fr(99)));

      // Randomized traffic: fill-heavy phase, then drain-heavy phase
      hi_left = 0;
      lo_left = 3;
      for (int cyc = 0; cyc < 700; cyc++) begin
         int pop_pct;
         pop_pct  = (cyc < 300) ? 3 : 35;
         pop_i    = ($urandom_range(0, 99) < pop_pct);
         clr_i    = ($urandom_range(0, 29) == 0);
         offset_i = DL2'($urandom_range(0, 15));
         if (wpulse_i) begin
            hi_left--;
            if (hi_left == 0) begin
               wpulse_i = 1'b0;
               lo_left  = $urandom_range(2, 6);
            end
         end else begin
            lo_left--;
            if (lo_left == 1) data_i = FW'({$urandom(), $urandom()});
            if (lo_left == 0) begin
               #($urandom_range(1, 12));
               wpulse_i = 1'b1;
               hi_left  = $urandom_range(2, 4);
            end
         end
         cycle();
      end
      pop_i    = 1'b0;
      clr_i    = 1'b0;
      wpulse_i = 1'b0;
      repeat (4) cycle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
